// File: rtl/bram_play_x2.sv
// bram_play_x2: streams BRAM words out as two half-width AXI4-Stream beats each (low half first).
// Build option PLAY_LOOP_EN: repeat the pass while loop_i is high when the last address issues.
//
// state | meaning
// IDLE  | waiting for a play edge; done_o high
// RUN   | issuing BRAM reads as FIFO credit allows
// DRAIN | all reads issued; emptying the FIFO until the final tlast
module bram_play_x2 #(
    parameter int DWIDTH_IN  = 256,
    parameter int DWIDTH_OUT = 128,
    parameter int MAX_XFER   = 2048,
    localparam int ADDR_BITS = $clog2(MAX_XFER)
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   play_i,
    input  logic [ADDR_BITS:0]     len_i,
    input  logic                   loop_i,
    output logic                   done_o,
    output logic [DWIDTH_OUT-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [31:0]            bram_addr,
    output logic                   bram_en,
    output logic [DWIDTH_IN/8-1:0] bram_we,
    output logic [DWIDTH_IN-1:0]   bram_wdata,
    output logic                   bram_clk,
    output logic                   bram_rst,
    input  logic [DWIDTH_IN-1:0]   bram_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int FIFO_DEPTH = 4;

    localparam logic [ADDR_BITS:0]   LEN_ONE  = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS:0]   MAX_LEN  = (ADDR_BITS + 1)'(MAX_XFER);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    logic [1:0]           state;
    logic                 play_q;
    logic                 play_qq;
    logic                 play_edge;
    logic [ADDR_BITS:0]   len_q;
    logic [ADDR_BITS:0]   len_clamped;
    logic [ADDR_BITS-1:0] addr;

    logic                 rd_v1;
    logic                 rd_v2;
    logic                 rd_last1;
    logic                 rd_last2;

    logic [DWIDTH_IN-1:0]  fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            occ;
    logic                  half;

    logic [2:0]           pending;
    logic                 issue;
    logic                 issue_last;
    logic                 loop_now;
    logic                 push;
    logic                 pop;
    logic                 beat_hs;
    logic                 final_beat;
    logic [DWIDTH_IN-1:0] head_word;

`ifdef PLAY_LOOP_EN
    assign loop_now = loop_i;
`else
    logic loop_unused;
    assign loop_unused = loop_i;
    assign loop_now    = 1'b0;
`endif

    assign play_edge   = play_q & ~play_qq;
    assign len_clamped = (len_i > MAX_LEN) ? MAX_LEN : len_i;

    // Credit covers words already in the FIFO plus reads still in the BRAM pipeline.
    assign pending    = occ + {2'b00, rd_v1} + {2'b00, rd_v2};
    assign issue      = (state == S_RUN) && (pending < 3'd4);
    assign issue_last = ({1'b0, addr} == (len_q - LEN_ONE));

    assign head_word = fifo_data[rd_ptr];
    assign push      = rd_v2;
    assign beat_hs   = m_axis_tvalid & m_axis_tready;
    assign pop       = beat_hs & half;

    // Last word of the last pass: nothing left behind it in the FIFO or in flight.
    assign final_beat = pop & fifo_last[rd_ptr] & (occ == 3'd1) & ~rd_v1 & ~rd_v2;

    always_comb begin
        m_axis_tvalid = (occ != 3'd0);
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        if (m_axis_tvalid) begin
            m_axis_tdata = half ? head_word[DWIDTH_IN-1:DWIDTH_OUT] : head_word[DWIDTH_OUT-1:0];
            m_axis_tlast = half & fifo_last[rd_ptr];
        end
    end

    assign done_o     = (state == S_IDLE);
    assign bram_en    = issue;
    assign bram_addr  = 32'(addr);
    assign bram_we    = '0;
    assign bram_wdata = '0;
    assign bram_clk   = aclk;
    assign bram_rst   = areset;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= S_IDLE;
            // Loading the live input hides a play level already high during reset.
            play_q    <= play_i;
            play_qq   <= play_i;
            len_q     <= '0;
            addr      <= '0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
            rd_last1  <= 1'b0;
            rd_last2  <= 1'b0;
            fifo_last <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            half      <= 1'b0;
        end else begin
            play_q   <= play_i;
            play_qq  <= play_q;
            rd_v1    <= issue;
            rd_last1 <= issue & issue_last;
            rd_v2    <= rd_v1;
            rd_last2 <= rd_last1;

            if (push) begin
                fifo_last[wr_ptr] <= rd_last2;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
            if (beat_hs) begin
                half <= ~half;
            end

            case (state)
                S_IDLE: begin
                    if (play_edge && (len_i != '0)) begin
                        state <= S_RUN;
                        len_q <= len_clamped;
                        addr  <= '0;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (issue_last) begin
                            if (loop_now) begin
                                addr <= '0;
                            end else begin
                                state <= S_DRAIN;
                            end
                        end else begin
                            addr <= addr + ADDR_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (final_beat) begin
                        state <= S_IDLE;
                        addr  <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone says what is valid.
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bram_rdata;
        end
    end

endmodule

// File: doc/bram_play_x2.md
BRAM_PLAY_X2 -- requirements
Module: bram_play_x2

Interface
REQ-001 Parameter DWIDTH_IN, default 256, SHALL be the BRAM word width.
REQ-002 Parameter DWIDTH_OUT, default 128, SHALL be the stream beat width; DWIDTH_IN = 2*DWIDTH_OUT.
REQ-003 Parameter MAX_XFER, default 2048, power of 2, SHALL be the maximum words per pass; ADDR_BITS = clog2(MAX_XFER).
REQ-004 Port aclk, in, 1: the single clock; all logic on its rising edge.
REQ-005 Port areset, in, 1: reset, synchronous, active-high.
REQ-006 Port play_i, in, 1: playback start request, rising-edge detected.
REQ-007 Port len_i, in, ADDR_BITS+1: words per pass, sampled at start.
REQ-008 Port loop_i, in, 1: repeat-pass request.
REQ-009 Port done_o, out, 1: high when idle.
REQ-010 Ports m_axis_tdata (DWIDTH_OUT), m_axis_tvalid, m_axis_tlast out; m_axis_tready in: AXI4-Stream master.
REQ-011 Ports bram_addr (32, word index, zero-extended), bram_en, bram_we (DWIDTH_IN/8), bram_wdata (DWIDTH_IN), bram_clk, bram_rst out; bram_rdata (DWIDTH_IN) in: Xilinx BRAM master, read-only.

Function
REQ-012 bram_we and bram_wdata SHALL be constant zero; bram_clk = aclk; bram_rst = areset.
REQ-013 BRAM read latency SHALL be 2 cycles: bram_rdata valid 2 cycles after bram_en high with an address.
REQ-014 States SHALL be IDLE, RUN, DRAIN.
REQ-015 IDLE -> RUN on play_i rising edge (play_i registered, edge = current high & previous low); len_i latched; address counter cleared to 0.
REQ-016 len_i = 0 SHALL be ignored (stay IDLE); len_i > MAX_XFER SHALL clamp to MAX_XFER.
REQ-017 Play edges outside IDLE SHALL be ignored.
REQ-018 In RUN, a read SHALL issue (bram_en = 1) only when FIFO occupancy plus reads in flight < 4; each issue increments the address.
REQ-019 Read data SHALL enter a 4-word prefetch FIFO; it never overflows and never drops data under any tready pattern.
REQ-020 Each FIFO word SHALL emit two beats: bits [DWIDTH_OUT-1:0] first, then upper half; word popped on upper-half handshake.
REQ-021 tvalid SHALL be high whenever a beat is available; tdata/tvalid/tlast SHALL hold stable while tvalid & !tready.
REQ-022 First beat SHALL reach tvalid no later than 4 cycles after the start edge; with tready held high, output SHALL sustain one beat per cycle without gaps.
REQ-023 tlast SHALL be high on the upper-half beat of word len-1 of each pass, else low.
REQ-024 After issuing address len-1 (non-loop), state -> DRAIN; DRAIN -> IDLE on the tlast handshake of the final pass.
REQ-025 done_o SHALL be high in IDLE only, low from the cycle after the start edge.

Reset
REQ-026 areset SHALL force IDLE, empty FIFO, in-flight reads discarded, address 0, bram_en 0, tvalid 0, tlast 0, tdata 0, done_o 1; it SHALL take effect mid-transfer on the next edge.
REQ-027 After reset, no play edge SHALL be detected if play_i was already high during reset.

Configuration
REQ-028 With PLAY_LOOP_EN defined: loop_i sampled when address len-1 issues; if high, address wraps to 0 and RUN continues seamlessly (no output gap, tlast still marks each pass end); if low, proceeds to DRAIN.
REQ-029 Without PLAY_LOOP_EN: loop_i port present but ignored; every run is a single pass.

Verification
REQ-030 BRAM word k = {k+0x1000, k}, len_i=4, tready=1, pulse play_i -> 8 beats 0,0x1000,1,0x1001,...,3,0x1003; tlast on beat 8 only; done_o high after.
REQ-031 len_i=16, tready random 30% duty -> all 32 beats in order, no duplicates/drops, stable tdata during stalls, bram_en never issues with 4 words pending.
REQ-032 len_i=0 and len_i=MAX_XFER+5 -> first: no bram_en, done_o stays 1; second: exactly 2*MAX_XFER beats, last address MAX_XFER-1.
REQ-033 areset asserted at beat 5 of a len_i=8 run -> next cycle tvalid 0, done_o 1; new play edge restarts from address 0.
REQ-034 PLAY_LOOP_EN defined, len_i=3, loop_i high for two passes then low -> 18 beats gapless, tlast on beats 6, 12, 18, then IDLE.
REQ-035 Second play_i edge during RUN -> ignored; beat count equals single pass.
